ncl_tx_bridge: RTL and testbench

//  Clocked producer end of an NCL dual-rail four-phase channel. Takes words from a

---
 rtl/ncl_pkg.sv | 22 ++
 rtl/ncl_sync.sv | 27 ++
 rtl/ncl_tx_bridge.sv | 109 ++++++++++
 tb/tb_ncl_tx_bridge.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_pkg.sv
// Shared types and dual-rail encoding constants for the NCL transmit bridge.
package ncl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_NULL = 2'd2
    } state_t;

    // Dual-rail pair encoding, packed as {T,F}
    localparam logic [1:0] DR_NULL  = 2'b00;
    localparam logic [1:0] DR_DATA0 = 2'b01;
    localparam logic [1:0] DR_DATA1 = 2'b10;

    localparam logic KI_RFD = 1'b1;
    localparam logic KI_RFN = 1'b0;

    function automatic logic [1:0] dr_encode(input logic b);
        return b ? DR_DATA1 : DR_DATA0;
    endfunction

endpackage

// File: rtl/ncl_sync.sv
// N-stage reset-to-zero flop chain used to bring the NCL completion signal into CLK.
module ncl_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    if (STAGES == 1) begin : g_one
        always_ff @(posedge i_clk) begin
            if (i_rst) r_chain <= '0;
            else       r_chain <= i_d;
        end
    end else begin : g_multi
        always_ff @(posedge i_clk) begin
            if (i_rst) r_chain <= '0;
            else       r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/ncl_tx_bridge.sv
// Valid/ready stream to NCL dual-rail four-phase producer, paced by consumer KI.
// Define NCL_TX_SYNC_EN to pass KI through a SYNC_STAGES synchronizer instead of one flop.
module ncl_tx_bridge
    import ncl_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NULL_CYC    = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             KI,
    output logic [WIDTH-1:0] D_T,
    output logic [WIDTH-1:0] D_F,
    output logic             BUSY
);

`ifdef NCL_TX_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    localparam int unsigned SYNC_N    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned KI_STAGES = SYNC_EN ? SYNC_N : 1;
    localparam int unsigned NULL_N    = (NULL_CYC < 1) ? 1 : NULL_CYC;
    localparam int unsigned CW        = $clog2(NULL_N + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(NULL_N);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dt;
    logic [WIDTH-1:0] r_df;
    logic             r_busy;

    logic             w_ki_s;
    logic             w_cnt_zero;
    logic             w_accept;

    ncl_sync #(
        .STAGES (KI_STAGES)
    ) u_ki_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (KI),
        .o_q   (w_ki_s)
    );

    assign w_cnt_zero = (r_cnt == '0);
    assign IN_READY   = (r_state == S_IDLE) && (w_ki_s == KI_RFD) && w_cnt_zero;
    assign w_accept   = IN_VALID && IN_READY;

    // Wavefront FSM; the spacer counter also drains in S_IDLE so reset enforces a NULL gap
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                {r_dt[i], r_df[i]} <= DR_NULL;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - CW'(1);
                    if (w_accept) begin
                        r_state <= S_DATA;
                        r_busy  <= 1'b1;
                        for (int i = 0; i < int'(WIDTH); i++) begin
                            {r_dt[i], r_df[i]} <= dr_encode(IN_DATA[i]);
                        end
                    end
                end
                S_DATA: begin
                    if (w_ki_s == KI_RFN) begin
                        r_state <= S_NULL;
                        r_cnt   <= CNT_LOAD;
                        for (int i = 0; i < int'(WIDTH); i++) begin
                            {r_dt[i], r_df[i]} <= DR_NULL;
                        end
                    end
                end
                S_NULL: begin
                    if (w_cnt_zero) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    for (int i = 0; i < int'(WIDTH); i++) begin
                        {r_dt[i], r_df[i]} <= DR_NULL;
                    end
                end
            endcase
        end
    end

    assign D_T  = r_dt;
    assign D_F  = r_df;
    assign BUSY = r_busy;

endmodule

// File: tb/tb_ncl_tx_bridge.sv
// Self-checking bench for ncl_tx_bridge: directed steps then randomized traffic vs a timeline model.
module tb_ncl_tx_bridge;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int NULL_CYC    = 1;
`ifdef NCL_TX_SYNC_EN
    localparam int LAG = SYNC_STAGES;
`else
    localparam int LAG = 1;
`endif
    localparam int MAXCYC = 20000;

    logic             CLK = 1'b0;
    logic             RST;
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic             KI;
    logic [WIDTH-1:0] D_T;
    logic [WIDTH-1:0] D_F;
    logic             BUSY;

    always #5 CLK = ~CLK;

    ncl_tx_bridge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .NULL_CYC    (NULL_CYC)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .KI       (KI),
        .D_T      (D_T),
        .D_F      (D_F),
        .BUSY     (BUSY)
    );

    int n_vec = 0;
    int n_err = 0;

    // Timeline model: a word sits on the rails from acceptance until ki_s is seen low;
    // afterwards NULL/busy lasts until idle_at, and a new word may go once ready_at has passed.
    int               edge_n   = 0;
    int               last_rst = -1000;
    bit               ki_at [MAXCYC];
    bit               m_data   = 1'b0;
    logic [WIDTH-1:0] m_word   = '0;
    int               idle_at  = 0;
    int               ready_at = 0;
    bit               m_kis    = 1'b0;
    bit               m_ready  = 1'b0;
    bit               m_acc    = 1'b0;

    int               kimode   = 0;
    bit               src_auto = 1'b0;
    int               null_run = 0;
    logic [WIDTH-1:0] obs_q [$];
    int               gap_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [WIDTH-1:0] e_dt;
        logic [WIDTH-1:0] e_df;
        logic [WIDTH-1:0] rails;
        @(posedge CLK);
        edge_n++;
        ki_at[edge_n] = KI;
        m_acc = 1'b0;
        if (RST) begin
            last_rst = edge_n;
            m_data   = 1'b0;
            idle_at  = edge_n;
            ready_at = edge_n + NULL_CYC;
        end else if (m_data) begin
            if (!m_kis) begin
                m_data   = 1'b0;
                idle_at  = edge_n + NULL_CYC + 1;
                ready_at = idle_at;
            end
        end else if (IN_VALID && m_ready) begin
            m_data = 1'b1;
            m_word = IN_DATA;
            m_acc  = 1'b1;
        end
        m_kis   = (edge_n - last_rst < LAG) ? 1'b0 : ki_at[edge_n - LAG + 1];
        m_ready = !m_data && (edge_n >= ready_at) && m_kis;

        @(negedge CLK);
        e_dt = m_data ? m_word : '0;
        e_df = m_data ? WIDTH'(~m_word) : '0;
        check("d_t", D_T, e_dt);
        check("d_f", D_F, e_df);
        check("busy", BUSY, m_data || (edge_n < idle_at));
        check("in_ready", IN_READY, m_ready);
        check("rail_excl", D_T & D_F, 0);

        rails = D_T | D_F;
        if (rails == '0) begin
            null_run++;
        end else if (null_run > 0) begin
            obs_q.push_back(D_T);
            gap_q.push_back(null_run);
            null_run = 0;
        end

        if (kimode == 1) begin
            if (rails == '1 && $urandom_range(0, 1) == 1) KI = 1'b0;
            else if (rails == '0 && $urandom_range(0, 1) == 1) KI = 1'b1;
        end else if (kimode == 2) begin
            if ($urandom_range(0, 7) == 0) KI = ~KI;
        end

        if (src_auto) begin
            if (m_acc) IN_VALID = 1'b0;
            if (!IN_VALID && $urandom_range(0, 3) == 0) begin
                IN_VALID = 1'b1;
                IN_DATA  = WIDTH'($urandom);
            end
            RST = ($urandom_range(0, 299) == 0);
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!IN_READY && k < 40) begin
            step();
            k++;
        end
        check(tag, IN_READY, 1);
    endtask

    initial begin
        #2_000_000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] stream [3];
        int k;
        stream[0] = 8'h00;
        stream[1] = 8'hFF;
        stream[2] = 8'h81;

        // 1: reset, KI high
        RST = 1'b1; KI = 1'b1; IN_VALID = 1'b0; IN_DATA = '0;
        repeat (3) step();
        check("rst_busy", BUSY, 0);
        check("rst_rails", D_T | D_F, 0);
        RST = 1'b0;
        wait_ready("post_rst_ready");

        // 2: single word then RFN
        IN_DATA = 8'hA5; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        check("t2_dt", D_T, 8'hA5);
        check("t2_df", D_F, 8'h5A);
        check("t2_busy", BUSY, 1);
        KI = 1'b0;
        repeat (LAG) step();
        check("t2_hold_dt", D_T, 8'hA5);
        step();
        check("t2_null", D_T | D_F, 0);
        KI = 1'b1;
        wait_ready("t2_ready");

        // 3: back-pressure with a second word waiting
        IN_DATA = 8'hA5; IN_VALID = 1'b1;
        step();
        IN_DATA = 8'h3C;
        repeat (20) step();
        check("t3_dt", D_T, 8'hA5);
        check("t3_df", D_F, 8'h5A);
        check("t3_ready", IN_READY, 0);
        KI = 1'b0;
        repeat (LAG + 1) step();
        check("t3_null", D_T | D_F, 0);
        KI = 1'b1;
        k = 0;
        while (D_T == '0 && k < 40) begin step(); k++; end
        IN_VALID = 1'b0;
        check("t3_second", D_T, 8'h3C);
        KI = 1'b0;
        repeat (LAG + NULL_CYC + 4) step();
        KI = 1'b1;
        repeat (LAG + 2) step();

        // 4: stream with echoing consumer
        obs_q.delete(); gap_q.delete();
        kimode = 1;
        foreach (stream[i]) begin
            IN_DATA = stream[i]; IN_VALID = 1'b1;
            k = 0;
            do begin step(); k++; end while (!m_acc && k < 60);
            check("t4_accept", m_acc, 1);
            IN_VALID = 1'b0;
        end
        k = 0;
        while ((BUSY || !IN_READY) && k < 60) begin step(); k++; end
        check("t4_count", obs_q.size(), 3);
        foreach (obs_q[i]) begin
            if (i < 3) check("t4_word", obs_q[i], stream[i]);
            check("t4_gap", gap_q[i] >= NULL_CYC, 1);
        end
        kimode = 0; KI = 1'b1;

        // 5: reset while DATA is on the rails
        wait_ready("t5_ready");
        IN_DATA = 8'hA5; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        check("t5_dt", D_T, 8'hA5);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("t5_rst_rails", D_T | D_F, 0);
        check("t5_rst_busy", BUSY, 0);

        // 6: KI rise to IN_READY latency
        KI = 1'b0;
        repeat (10) step();
        KI = 1'b1;
        k = 0;
        while (!IN_READY && k < 20) begin step(); k++; end
        check("t6_lag", k, LAG);

        // Randomized traffic with echoing and glitchy consumers plus sporadic reset
        src_auto = 1'b1;
        for (int blk = 0; blk < 16; blk++) begin
            kimode = (blk % 2 == 0) ? 1 : 2;
            repeat (200) step();
        end
        src_auto = 1'b0;
        RST = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
